// File: rtl/booth_mul_sched_if.sv
// booth_mul_sched_if: requester/response bundle for the shared Booth multiplier.
interface booth_mul_sched_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [2*WIDTH-1:0]    resp_p;
    logic                  busy;
    modport master (
        output req_valid, req_x, req_y, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_p, busy
    );
    modport slave (
        input  req_valid, req_x, req_y, resp_ready,
        output req_ready, resp_valid, resp_id, resp_p, busy
    );
endinterface

// File: rtl/booth_mul_sched.sv
// booth_mul_sched: round-robin scheduler sharing one radix-4 Booth multiplier core.
module booth #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] p
);
    logic [2*WIDTH-1:0] xe;
    logic [2*WIDTH-1:0] pp;
    logic [WIDTH:0]     yb;
    logic [2:0]         t;
    // Partial products are formed at full 2*WIDTH so -2x of the most negative x stays exact.
    always_comb begin
        xe = {{WIDTH{x[WIDTH-1]}}, x};
        yb = {y, 1'b0};
        p  = '0;
        pp = '0;
        t  = '0;
        for (int j = 0; j < WIDTH/2; j++) begin
            t  = yb[2*j +: 3];
            pp = (t == 3'b001 || t == 3'b010) ? xe :
                 (t == 3'b011)                ? xe << 1 :
                 (t == 3'b100)                ? -(xe << 1) :
                 (t == 3'b101 || t == 3'b110) ? -xe : '0;
            p  = p + (pp << (2*j));
        end
    end
endmodule

module booth_mul_sched #(
    parameter int WIDTH      = 32,
    parameter int NREQ       = 4,
    parameter int MUL_CYCLES = 2
) (
    input logic              clk,
    input logic              rst,
    booth_mul_sched_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = 4;
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
    state_t             state, state_n;
    logic [IDW-1:0]     rr_last, grant, idx, op_id;
    logic               found, hs;
    logic [WIDTH-1:0]   op_x, op_y;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    // Search starts just past the last winner so every waiting requester gets a turn.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(rr_last) + k) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end
    assign hs            = (state == IDLE) && found;
    assign bus.req_ready = hs ? NREQ'(1) << grant : '0;
    assign bus.busy      = state != IDLE;
    always_comb begin
        state_n = state;
        if (state == IDLE && found)
            state_n = MUL;
        else if (state == MUL && cnt == '0)
            state_n = RESP;
        else if (state == RESP && bus.resp_ready)
            state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    booth #(.WIDTH(WIDTH)) core (.x(op_x), .y(op_y), .p(prod));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last        <= IDW'(NREQ - 1);
            op_x           <= '0;
            op_y           <= '0;
            op_id          <= '0;
            cnt            <= '0;
            bus.resp_p     <= '0;
            bus.resp_id    <= '0;
            bus.resp_valid <= 1'b0;
        end else begin
            if (hs) begin
                op_x    <= bus.req_x[grant*WIDTH +: WIDTH];
                op_y    <= bus.req_y[grant*WIDTH +: WIDTH];
                op_id   <= grant;
                rr_last <= grant;
                cnt     <= CW'(MUL_CYCLES - 1);
            end
            if (state == MUL && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == MUL && cnt == '0) begin
                bus.resp_p     <= prod;
                bus.resp_id    <= op_id;
                bus.resp_valid <= 1'b1;
            end
            if (state == RESP && bus.resp_ready)
                bus.resp_valid <= 1'b0;
        end
    end
endmodule
